sc_score_display: RTL and testbench

- Consumer end of the score counter interface.
- Takes the 8-bit binary score bus and the active-low end-of-count flag from the score counter.
- Converts the score to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives three active-low 7-segment digit outputs for the board display, and blinks the display while end-of-count is asserted.

---
 rtl/sc_score_display.sv | 165 ++++++++++++++++
 tb/tb_sc_score_display.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_score_display.sv
// sc_score_display: score counter consumer. Converts the binary score to
// three BCD digits with a sequential shift-add-3 engine and drives three
// active-low 7-segment digits (gfedcba), blinking while end-of-count is low.
// Optional build macro: SCORE_DISPLAY_BLANK_ZEROS_EN enables leading-zero
// blanking on the hundreds and tens digits.
module sc_score_display #(
  parameter int unsigned N          = 8,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic         SC_COUNTER_SCORE_CLOCK,
  input  logic         SC_COUNTER_SCORE_RESET_InLow,
  input  logic [N-1:0] SC_SCORE_DISPLAY_SCORE,
  input  logic         SC_SCORE_DISPLAY_ENDCOUNT_InLow,
  output logic         SC_SCORE_DISPLAY_BUSY,
  output logic         SC_SCORE_DISPLAY_VALID,
  output logic [11:0]  SC_SCORE_DISPLAY_BCD,
  output logic [6:0]   SC_SCORE_DISPLAY_HEX2,
  output logic [6:0]   SC_SCORE_DISPLAY_HEX1,
  output logic [6:0]   SC_SCORE_DISPLAY_HEX0
);

  localparam int unsigned BCD_W  = 12;
  localparam int unsigned ITER_W = $clog2(N + 1);
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [N-1:0]        r_shift;
  logic [N-1:0]        r_capture;
  logic [N-1:0]        r_last;
  logic [BCD_W-1:0]    r_work;
  logic [BCD_W-1:0]    r_bcd;
  logic [ITER_W-1:0]   r_iter;
  logic                r_busy;
  logic                r_valid;
  logic [BLINK_BITS-1:0] r_blink;

  logic [BCD_W-1:0]    w_adj;
  logic                w_blank;
  logic [6:0]          w_seg2;
  logic [6:0]          w_seg1;
  logic [6:0]          w_seg0;

  // Active-low gfedcba pattern for one BCD nibble; non-decimal codes blank.
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction on every work nibble of 5 or more before the shift.
  always_comb begin
    w_adj = r_work;
    for (int k = 0; k < 3; k++) begin
      if (r_work[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: detect a new score, run N shift iterations, latch digits.
  always_ff @(posedge SC_COUNTER_SCORE_CLOCK or negedge SC_COUNTER_SCORE_RESET_InLow) begin
    if (!SC_COUNTER_SCORE_RESET_InLow) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_capture <= '0;
      r_last    <= '0;
      r_work    <= '0;
      r_bcd     <= '0;
      r_iter    <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (SC_SCORE_DISPLAY_SCORE != r_last) begin
            r_shift   <= SC_SCORE_DISPLAY_SCORE;
            r_capture <= SC_SCORE_DISPLAY_SCORE;
            r_work    <= '0;
            r_iter    <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_work  <= {w_adj[BCD_W-2:0], r_shift[N-1]};
          r_shift <= {r_shift[N-2:0], 1'b0};
          r_iter  <= r_iter + ITER_W'(1);
          if (r_iter == ITER_W'(N - 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_bcd   <= r_work;
          r_last  <= r_capture;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Free-running blink phase counter; wraps silently.
  always_ff @(posedge SC_COUNTER_SCORE_CLOCK or negedge SC_COUNTER_SCORE_RESET_InLow) begin
    if (!SC_COUNTER_SCORE_RESET_InLow) begin
      r_blink <= '0;
    end else begin
      r_blink <= r_blink + BLINK_BITS'(1);
    end
  end

  // Digit decode with optional leading-zero blanking.
  always_comb begin
    w_seg2 = f_seg(r_bcd[11:8]);
    w_seg1 = f_seg(r_bcd[7:4]);
    w_seg0 = f_seg(r_bcd[3:0]);
`ifdef SCORE_DISPLAY_BLANK_ZEROS_EN
    if (r_bcd[11:8] == 4'd0) begin
      w_seg2 = SEG_BLANK;
      if (r_bcd[7:4] == 4'd0) begin
        w_seg1 = SEG_BLANK;
      end
    end
`else
    w_seg2 = f_seg(r_bcd[11:8]);
`endif
  end

  // End-of-count blinking blanks all three digits during the high blink phase.
  always_comb begin
    w_blank = ~SC_SCORE_DISPLAY_ENDCOUNT_InLow & r_blink[BLINK_BITS-1];
    SC_SCORE_DISPLAY_HEX2 = w_blank ? SEG_BLANK : w_seg2;
    SC_SCORE_DISPLAY_HEX1 = w_blank ? SEG_BLANK : w_seg1;
    SC_SCORE_DISPLAY_HEX0 = w_blank ? SEG_BLANK : w_seg0;
  end

  assign SC_SCORE_DISPLAY_BUSY  = r_busy;
  assign SC_SCORE_DISPLAY_VALID = r_valid;
  assign SC_SCORE_DISPLAY_BCD   = r_bcd;

endmodule

// File: tb/tb_sc_score_display.sv
// tb_sc_score_display: directed plus random checks of sc_score_display
// against a decimal-arithmetic reference model (N=8, BLINK_BITS=4).
module tb_sc_score_display;

  localparam int unsigned N  = 8;
  localparam int unsigned BB = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] score;
  logic         endc_n;
  logic         busy;
  logic         valid;
  logic [11:0]  bcd;
  logic [6:0]   hex2, hex1, hex0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [11:0] m_bcd;
  logic [7:0]  m_last;

  sc_score_display #(.N(N), .BLINK_BITS(BB)) dut (
    .SC_COUNTER_SCORE_CLOCK          (clk),
    .SC_COUNTER_SCORE_RESET_InLow    (rst_n),
    .SC_SCORE_DISPLAY_SCORE          (score),
    .SC_SCORE_DISPLAY_ENDCOUNT_InLow (endc_n),
    .SC_SCORE_DISPLAY_BUSY           (busy),
    .SC_SCORE_DISPLAY_VALID          (valid),
    .SC_SCORE_DISPLAY_BCD            (bcd),
    .SC_SCORE_DISPLAY_HEX2           (hex2),
    .SC_SCORE_DISPLAY_HEX1           (hex1),
    .SC_SCORE_DISPLAY_HEX0           (hex0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release: the blink phase is bit BB-1 of this count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [11:0] to_bcd(input int s);
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {HEX2,HEX1,HEX0} from the digits, end-of-count flag and cycle count.
  function automatic logic [20:0] exp_hex(input logic [11:0] b, input logic e, input int c);
    int h, t, u;
    logic [6:0] s2, s1, s0;
    h = int'(b[11:8]); t = int'(b[7:4]); u = int'(b[3:0]);
    s2 = seg(h); s1 = seg(t); s0 = seg(u);
`ifdef SCORE_DISPLAY_BLANK_ZEROS_EN
    if (h == 0) s2 = 7'b1111111;
    if (h == 0 && t == 0) s1 = 7'b1111111;
`endif
    if (!e && ((c % (1 << BB)) >= (1 << (BB - 1)))) return {21{1'b1}};
    return {s2, s1, s0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag);
    chk(tag, 32'({hex2, hex1, hex0}), 32'(exp_hex(m_bcd, endc_n, cyc)));
  endtask

  // Apply a score that differs from the last converted one and follow it through.
  task automatic convert(input logic [7:0] s);
    @(negedge clk);
    score = s;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("busy_run", 32'(busy), 32'(1));
      chk("valid_run", 32'(valid), 32'(0));
    end
    @(negedge clk);
    m_bcd  = to_bcd(int'(s));
    m_last = s;
    chk("valid_done", 32'(valid), 32'(1));
    chk("busy_done", 32'(busy), 32'(0));
    chk("bcd_done", 32'(bcd), 32'(m_bcd));
    chk_disp("hex_done");
    @(negedge clk);
    chk("valid_drop", 32'(valid), 32'(0));
  endtask

  initial begin
    int vcount;
    int blanks;
    logic [7:0] s;

    rst_n  = 1'b0;
    score  = '0;
    endc_n = 1'b1;
    m_bcd  = '0;
    m_last = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_bcd", 32'(bcd), 32'(0));
    chk_disp("rst_hex");
`ifndef SCORE_DISPLAY_BLANK_ZEROS_EN
    chk("rst_hex_const", 32'({hex2, hex1, hex0}), 32'({3{7'b1000000}}));
`endif
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'(0));
    end

    // Directed values from the plan
    convert(8'd57);
`ifndef SCORE_DISPLAY_BLANK_ZEROS_EN
    chk("hex57", 32'({hex2, hex1, hex0}), 32'({7'b1000000, 7'b0010010, 7'b1111000}));
`endif
    convert(8'd255);
    chk("hex255", 32'({hex2, hex1, hex0}), 32'({7'b0100100, 7'b0010010, 7'b0010010}));
`ifdef SCORE_DISPLAY_BLANK_ZEROS_EN
    convert(8'd7);
    chk("hex7_blank", 32'({hex2, hex1, hex0}), 32'({7'b1111111, 7'b1111111, 7'b1111000}));
    convert(8'd100);
    chk("hex100_blank", 32'({hex2, hex1, hex0}), 32'({7'b1111001, 7'b1000000, 7'b1000000}));
`endif

    // Score changes mid-conversion: 92 completes, then 93 after one idle cycle
    @(negedge clk);
    score  = 8'd92;
    vcount = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 3) score = 8'd93;
      if (valid) vcount++;
      if (i == 10) chk("mid_bcd1", 32'(bcd), 32'(12'h092));
      if (i == 10) chk("mid_idle_gap", 32'(busy), 32'(0));
      if (i == 11) chk("mid_restart", 32'(busy), 32'(1));
      if (i == 20) chk("mid_bcd2", 32'(bcd), 32'(12'h093));
    end
    chk("mid_valid_count", 32'(vcount), 32'(2));
    m_bcd  = 12'h093;
    m_last = 8'd93;

    // Blinking while end-of-count is asserted
    convert(8'd92);
    endc_n = 1'b0;
    blanks = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk_disp("blink_hex");
      if ({hex2, hex1, hex0} == {21{1'b1}}) blanks++;
    end
    chk("blink_blank_count", 32'(blanks), 32'(16));
    endc_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk_disp("steady_hex");
    end

    // Random scores with random end-of-count level
    for (int n = 0; n < 20; n++) begin
      s = 8'($urandom_range(0, 255));
      if (s == m_last) s = s + 8'd1;
      endc_n = 1'($urandom_range(0, 1));
      convert(s);
      chk("rand_bcd_digits_ok", 32'(bcd[7:4] <= 4'd9 && bcd[3:0] <= 4'd9), 32'(1));
    end
    endc_n = 1'b1;

    // Reset mid-conversion aborts; a nonzero score restarts right after release
    @(negedge clk);
    score = (m_last == 8'd200) ? 8'd201 : 8'd200;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_bcd = '0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_valid", 32'(valid), 32'(0));
    chk("abort_bcd", 32'(bcd), 32'(0));
    chk_disp("abort_hex");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) chk("rerun_busy", 32'(busy), 32'(1));
    end
    m_bcd = to_bcd(int'(score));
    chk("rerun_valid", 32'(valid), 32'(1));
    chk("rerun_bcd", 32'(bcd), 32'(m_bcd));
    chk_disp("rerun_hex");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
